// File: rtl/sys_ctrl_bus_regs.sv
// Bus-side sys_ctrl configuration registers with shadowed muxsplit/vref and break-before-make commit.
// Optional: define SYS_CTRL_BUS_REGS_LOCK_EN to turn word 5 into a sticky write lock.
module sys_ctrl_bus_regs #(
    parameter int BBM_CYCLES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic [23:0] bus_muxsplit_sw,
    output logic        bus_vref_e_vrefgen_en,
    output logic        bus_vref_w_vrefgen_en,
    output logic [4:0]  bus_vref_e_ref_sel,
    output logic [4:0]  bus_vref_w_ref_sel,
    output logic        bus_user_ahb_enable,
    output logic [15:0] bus_user_irqs_enable,
    output logic [5:0]  bus_sio_cfg,
    input  logic        bus_mgmt_select
);

    localparam logic [7:0] BBM_LOAD = (BBM_CYCLES > 0) ? 8'(BBM_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_APPLY} state_t;

    state_t                 state, state_nxt;
    logic [7:0]             cnt, cnt_nxt;
    logic [23:0]            mux_shadow, mux_pend, mux_live;
    logic [11:0]            vref_shadow, vref_pend, vref_live;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             widx;
    logic                   accept, wr_ok, busy, locked, illegal, start;
    logic [31:0]            rd_val;
    logic                   unused_addr_bits;

    assign widx             = addr[4:2];
    assign unused_addr_bits = ^addr[1:0];
    assign accept           = req && !ack;
    assign busy             = (state != ST_IDLE);
    assign wr_ok            = accept && we && !illegal;
    assign start            = wr_ok && (widx == 3'd3) && wdata[0];

`ifdef SYS_CTRL_BUS_REGS_LOCK_EN
    logic lock_q;
    always_ff @(posedge clk) begin
        if (rst)
            lock_q <= 1'b0;
        else if (wr_ok && widx == 3'd5 && wdata[7:0] == 8'hA5)
            lock_q <= 1'b1;
    end
    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    // Read mux and illegal-access decode; err is only emitted when accepted.
    always_comb begin
        rd_val  = '0;
        illegal = 1'b0;
        case (widx)
            3'd0: begin
                rd_val  = {8'd0, mux_shadow};
                illegal = we && locked;
            end
            3'd1: begin
                rd_val  = {20'd0, vref_shadow};
                illegal = we && locked;
            end
            3'd2: begin
                rd_val  = {bus_user_irqs_enable, 9'd0, bus_sio_cfg, bus_user_ahb_enable};
                illegal = we && locked;
            end
            3'd3: begin
                rd_val  = {31'd0, busy};
                illegal = we && (locked || (wdata[0] && busy));
            end
            3'd4: begin
                rd_val  = {31'd0, sync_q[SYNC_STAGES-1]};
                illegal = we;
            end
`ifdef SYS_CTRL_BUS_REGS_LOCK_EN
            3'd5: rd_val = {31'd0, lock_q};
`endif
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack                  <= 1'b0;
            err                  <= 1'b0;
            rdata                <= '0;
            mux_shadow           <= '0;
            mux_pend             <= '0;
            mux_live             <= '0;
            vref_shadow          <= '0;
            vref_pend            <= '0;
            vref_live            <= '0;
            bus_user_ahb_enable  <= 1'b0;
            bus_sio_cfg          <= '0;
            bus_user_irqs_enable <= '0;
        end else begin
            ack   <= accept;
            err   <= accept && illegal;
            rdata <= (accept && !we) ? rd_val : '0;
            if (wr_ok && widx == 3'd0) mux_shadow  <= wdata[23:0];
            if (wr_ok && widx == 3'd1) vref_shadow <= wdata[11:0];
            if (wr_ok && widx == 3'd2) begin
                bus_user_ahb_enable  <= wdata[0];
                bus_sio_cfg          <= wdata[6:1];
                bus_user_irqs_enable <= wdata[31:16];
            end
            // Snapshot at commit so shadow writes during the sequence wait for the next commit.
            if (start) begin
                mux_pend  <= mux_shadow;
                vref_pend <= vref_shadow;
            end
            if (state == ST_APPLY) begin
                mux_live  <= mux_pend;
                vref_live <= vref_pend;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            sync_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus_mgmt_select};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (BBM_CYCLES == 0) ? ST_APPLY : ST_BREAK;
                    cnt_nxt   = BBM_LOAD;
                end
            end
            ST_BREAK: begin
                if (cnt == 8'd0) state_nxt = ST_APPLY;
                else             cnt_nxt   = cnt - 8'd1;
            end
            ST_APPLY: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign bus_muxsplit_sw = (state == ST_BREAK) ? '0 : mux_live;
    assign {bus_vref_w_ref_sel, bus_vref_e_ref_sel,
            bus_vref_w_vrefgen_en, bus_vref_e_vrefgen_en} = vref_live;

endmodule

// File: tb/tb_sys_ctrl_bus_regs.sv
// Directed + random bench for sys_ctrl_bus_regs against a cycle-timeline reference model.
module tb_sys_ctrl_bus_regs;
    localparam int B = 4;
    localparam int S = 2;

    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        ack, err;
    logic [31:0] rdata;
    logic [23:0] bus_muxsplit_sw;
    logic        bus_vref_e_vrefgen_en, bus_vref_w_vrefgen_en;
    logic [4:0]  bus_vref_e_ref_sel, bus_vref_w_ref_sel;
    logic        bus_user_ahb_enable;
    logic [15:0] bus_user_irqs_enable;
    logic [5:0]  bus_sio_cfg;
    logic        bus_mgmt_select = 1'b0;

    sys_ctrl_bus_regs #(.BBM_CYCLES(B), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .err(err),
        .bus_muxsplit_sw(bus_muxsplit_sw),
        .bus_vref_e_vrefgen_en(bus_vref_e_vrefgen_en),
        .bus_vref_w_vrefgen_en(bus_vref_w_vrefgen_en),
        .bus_vref_e_ref_sel(bus_vref_e_ref_sel),
        .bus_vref_w_ref_sel(bus_vref_w_ref_sel),
        .bus_user_ahb_enable(bus_user_ahb_enable),
        .bus_user_irqs_enable(bus_user_irqs_enable),
        .bus_sio_cfg(bus_sio_cfg),
        .bus_mgmt_select(bus_mgmt_select)
    );

    always #5 clk = ~clk;

    int   n_assert = 0, n_fail = 0;
    int   cyc = 0, rst_cyc = -1000;
    logic hist [0:8191];
    bit   chk_en = 0;

    // Reference model: register contents plus the time of the last accepted commit.
    logic [23:0] m_mux_sh, m_old_mux, m_new_mux;
    logic [11:0] m_vref_sh, m_old_vref, m_new_vref;
    logic [31:0] m_user;
    bit          m_lock;
    int          k_commit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy(input int c);
        return (c >= k_commit) && (c <= k_commit + B);
    endfunction

    // Switches open for B cycles after the commit, old values during apply, new ones after.
    function automatic logic [23:0] e_mux(input int c);
        if (c < k_commit)      return m_old_mux;
        if (c < k_commit + B)  return 24'd0;
        if (c == k_commit + B) return m_old_mux;
        return m_new_mux;
    endfunction

    function automatic logic [11:0] e_vref(input int c);
        return (c <= k_commit + B) ? m_old_vref : m_new_vref;
    endfunction

    function automatic logic e_status(input int c);
        int i;
        i = c - S + 1;
        if (i <= rst_cyc || i < 0 || i > 8191) return 1'b0;
        return hist[i];
    endfunction

    task automatic model_reset();
        m_mux_sh = 0; m_old_mux = 0; m_new_mux = 0;
        m_vref_sh = 0; m_old_vref = 0; m_new_vref = 0;
        m_user = 0; m_lock = 0; k_commit = -1000;
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < 8192) hist[cyc] = bus_mgmt_select;
        if (rst) rst_cyc = cyc;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mux_out", {8'd0, bus_muxsplit_sw}, {8'd0, e_mux(cyc)});
            chk("vref_out", {20'd0, bus_vref_w_ref_sel, bus_vref_e_ref_sel,
                             bus_vref_w_vrefgen_en, bus_vref_e_vrefgen_en}, {20'd0, e_vref(cyc)});
            chk("user_out", {bus_user_irqs_enable, 9'd0, bus_sio_cfg, bus_user_ahb_enable},
                m_user & 32'hFFFF_007F);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        model_reset();
        chk_en = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic access(input bit w, input int widx, input logic [31:0] d);
        logic [31:0] e_rd;
        bit          e_err;
        int          k;
        @(negedge clk);
        req = 1'b1; we = w; wdata = d;
        addr = {3'(widx), 2'($urandom)};
        @(posedge clk); #1;
        k = cyc;
        e_rd = 0; e_err = 0;
        case (widx)
            0: e_rd = {8'd0, m_mux_sh};
            1: e_rd = {20'd0, m_vref_sh};
            2: e_rd = m_user & 32'hFFFF_007F;
            3: e_rd = {31'd0, m_busy(k - 1)};
            4: e_rd = {31'd0, e_status(k - 1)};
`ifdef SYS_CTRL_BUS_REGS_LOCK_EN
            5: e_rd = {31'd0, m_lock};
`endif
            default: e_err = 1;
        endcase
        if (w) begin
            e_rd = 0;
            if (widx == 4) e_err = 1;
            if (widx <= 3 && m_lock) e_err = 1;
            if (widx == 3 && d[0] && m_busy(k - 1)) e_err = 1;
        end
        chk("ack", {31'd0, ack}, 32'd1);
        chk("rdata", rdata, e_rd);
        chk("err", {31'd0, err}, {31'd0, e_err});
        if (w && !e_err) begin
            case (widx)
                0: m_mux_sh  = d[23:0];
                1: m_vref_sh = d[11:0];
                2: m_user    = d;
                3: if (d[0]) begin
                    m_old_mux = m_new_mux; m_old_vref = m_new_vref;
                    m_new_mux = m_mux_sh;  m_new_vref = m_vref_sh;
                    k_commit  = k;
                end
                5: if (d[7:0] == 8'hA5) m_lock = 1;
                default: ;
            endcase
        end
        // req still high on the ack cycle must not start another access
        @(posedge clk); #1;
        chk("ack_pulse", {30'd0, ack, err}, 32'd0);
        chk("rdata_idle", rdata, 32'd0);
        req = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();
        chk("reset_outputs", {8'd0, bus_muxsplit_sw} | {20'd0, bus_vref_w_ref_sel, bus_vref_e_ref_sel,
            bus_vref_w_vrefgen_en, bus_vref_e_vrefgen_en} | {bus_user_irqs_enable, 9'd0,
            bus_sio_cfg, bus_user_ahb_enable}, 32'd0);
        for (int i = 0; i < 5; i++) access(0, i, 0);

        // Full-scale commit with break phase
        access(1, 0, 32'h00FF_FFFF);
        access(1, 1, 32'h0000_0FFF);
        chk("shadow_not_live", {8'd0, bus_muxsplit_sw}, 32'd0);
        access(1, 3, 32'd1);
        access(0, 3, 0);
        idle(4);
        chk("mux_all_ones", {8'd0, bus_muxsplit_sw}, 32'h00FF_FFFF);
        chk("vref_e_sel", {27'd0, bus_vref_e_ref_sel}, 32'd31);

        // Disjoint switch sets: old and new never overlap
        access(1, 0, 32'h3);  access(1, 3, 32'd1); idle(6);
        access(1, 0, 32'h30); access(1, 3, 32'd1); idle(6);
        chk("mux_0x30", {8'd0, bus_muxsplit_sw}, 32'h30);

        // Commit during break is rejected; shadow write waits for the next commit
        access(1, 0, 32'h7); access(1, 3, 32'd1);
        access(1, 3, 32'd1);
        access(1, 0, 32'h1);
        idle(6);
        chk("mux_first_commit", {8'd0, bus_muxsplit_sw}, 32'h7);
        access(1, 3, 32'd1); idle(6);
        chk("mux_second_commit", {8'd0, bus_muxsplit_sw}, 32'h1);

        // USER register and reserved word
        access(1, 2, 32'hBEEF_007F);
        chk("ahb_en", {31'd0, bus_user_ahb_enable}, 32'd1);
        chk("sio_cfg", {26'd0, bus_sio_cfg}, 32'h3F);
        chk("irqs_en", {16'd0, bus_user_irqs_enable}, 32'hBEEF);
        access(0, 6, 0);
        access(1, 7, 32'hFFFF_FFFF);
        access(1, 4, 32'd1);

        // mgmt_select synchronizer latency
        @(negedge clk); bus_mgmt_select = 1'b1;
        access(0, 4, 0);
        idle(2);
        access(0, 4, 0);

`ifdef SYS_CTRL_BUS_REGS_LOCK_EN
        access(1, 5, 32'h0000_00A5);
        access(0, 5, 0);
        access(1, 2, 32'h1234_5678);
        chk("locked_user", {16'd0, bus_user_irqs_enable}, 32'hBEEF);
        access(1, 3, 32'd1);
        access(0, 2, 0);
`endif

        // Reset during a commit abandons it
        access(1, 0, 32'hABCDEF); access(1, 3, 32'd1);
        idle(1);
        do_reset();
        chk("reset_mid_commit", {8'd0, bus_muxsplit_sw}, 32'd0);
        access(0, 3, 0);

        // Random traffic
        for (int it = 0; it < 300; it++) begin
            int          w;
            logic [31:0] d;
            w = int'($urandom_range(7));
            d = $urandom;
            if (w == 5 && $urandom_range(15) == 0) d[7:0] = 8'hA5;
            if ($urandom_range(3) == 0) d[0] = 1'b1;
            access(1'($urandom), w, d);
            for (int g = int'($urandom_range(3)); g > 0; g--) begin
                @(negedge clk);
                if ($urandom_range(3) == 0) bus_mgmt_select = ~bus_mgmt_select;
            end
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sys_ctrl_bus_regs.md
Name: sys_ctrl_bus_regs

Overview:
- Bus-side register file for system control: the writer end of the sys_ctrl configuration interface.
- Holds the analog-switch, vref, user-AHB, user-IRQ and SIO configuration written by the management core over a simple req/ack register port.
- Drives the bus_* configuration nets consumed by the sys_ctrl pass-through block, and returns the synchronized mgmt_select status to software.
- Muxsplit and vref settings go through shadow registers and an atomic commit with a break-before-make sequence, so analog switches never short during reconfiguration.

Parameters:
- BBM_CYCLES, 4, cycles all muxsplit switches are forced open before new values are applied (0 = no break phase; legal range 0..255)
- SYNC_STAGES, 2, flops in the mgmt_select synchronizer (minimum 2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req  in  1  register access request; held high until ack
- we  in  1  1 = write, 0 = read; valid with req
- addr  in  5  byte address; word index = addr[4:2]; addr[1:0] ignored
- wdata  in  32  write data
- ack  out  1  single-cycle access-complete pulse
- rdata  out  32  read data; valid only while ack = 1, otherwise 0
- err  out  1  single-cycle pulse with ack on an illegal access
- bus_muxsplit_sw  out  24  live switch controls; bits [5:0] = se, [11:6] = sw, [17:12] = ne, [23:18] = nw; each 6-bit group in order aa_sl, aa_s0, bb_s0, bb_sl, bb_sr, aa_sr (LSB first)
- bus_vref_e_vrefgen_en  out  1  live east vref enable
- bus_vref_w_vrefgen_en  out  1  live west vref enable
- bus_vref_e_ref_sel  out  5  live east vref select
- bus_vref_w_ref_sel  out  5  live west vref select
- bus_user_ahb_enable  out  1  user AHB enable
- bus_user_irqs_enable  out  16  user IRQ enables
- bus_sio_cfg  out  6  SIO configuration
- bus_mgmt_select  in  1  asynchronous mgmt_select status

Behaviour:
- Register map (word index):
  - 0 MUXSPLIT: RW shadow, bits [23:0].
  - 1 VREF: RW shadow. [0] = e_en, [1] = w_en, [6:2] = e_sel, [11:7] = w_sel.
  - 2 USER: RW, live immediately. [0] = ahb_enable, [6:1] = sio_cfg, [31:16] = irqs_enable.
  - 3 CTRL: a write with wdata[0] = 1 starts a commit. A read returns [0] = busy.
  - 4 STATUS: RO, [0] = synchronized mgmt_select.
  - 5–7: reserved. Reads return 0, writes are ignored, and err pulses.
- Unused bits of every register read 0. Writes to the RO STATUS register are ignored and pulse err.
- Handshake:
  - The access is accepted on the first cycle req = 1 while ack = 0.
  - ack (and err if applicable) pulse exactly 1 cycle later. Latency = 1.
  - req held high on the ack cycle is not re-accepted. A new access needs req to be sampled again after ack, which gives at most 1 access every 2 cycles.
- Reset (rst = 1 at a clk edge):
  - All outputs 0, all shadows 0, FSM = IDLE, ack/err/rdata = 0, synchronizer flops = 0.
  - Reset mid-commit aborts the commit and leaves all outputs at 0.
- Commit FSM:
  - IDLE: on a CTRL commit write, go to BREAK (or straight to APPLY if BBM_CYCLES = 0) and load the counter with BBM_CYCLES − 1.
  - BREAK: bus_muxsplit_sw is forced to 0 and the vref outputs hold their old values. The counter decrements; at 0, go to APPLY. BREAK lasts exactly BBM_CYCLES cycles.
  - APPLY: for 1 cycle, load the live muxsplit and vref registers from the shadows. The new values are visible at the outputs from the cycle after APPLY. Then go to IDLE.
  - busy = 1 in BREAK and APPLY.
- A commit write while busy is ignored, gets ack plus err, and does not restart the sequence.
- Shadow writes while busy are accepted without error. They do not affect the commit in progress and are applied on the next commit.
- USER writes take effect at the outputs in the cycle after acceptance, independent of the FSM.
- STATUS[0] is bus_mgmt_select delayed through SYNC_STAGES flops.

Optional Feature:
- SYS_CTRL_BUS_REGS_LOCK_EN defined:
  - Word 5 becomes LOCK. Writing wdata[7:0] = 0xA5 sets a sticky lock bit; reads return [0] = lock.
  - While locked, writes to words 0–3 are ignored and pulse err. Reads are unaffected.
  - Only rst clears the lock.
- Macro undefined: word 5 is reserved, as in the register map above.

Test Plan:
- Reset, then read words 0–4 → rdata = 0 for each, ack 1 cycle after req, all bus_* outputs 0.
- Write MUXSPLIT = 0x00FFFFFF and VREF = 0x0FFF, check outputs still 0, write CTRL = 1 with BBM_CYCLES = 4 → bus_muxsplit_sw stays 0 for 4 BREAK cycles, then outputs 0xFFFFFF/all-ones vref the cycle after APPLY; CTRL read shows busy = 1 during the sequence.
- With live MUXSPLIT = 0x000003, commit shadow 0x000030 → exactly 4 cycles of 0x000000 between old and new, never 0x000033.
- Commit write during BREAK → ack + err, sequence length unchanged. A shadow write of 0x1 during BREAK applies only after a second commit.
- Write USER = 0xBEEF007F → next cycle ahb_enable = 1, sio_cfg = 0x3F, irqs_enable = 0xBEEF. Read word 6 → rdata = 0 with err.
- Toggle bus_mgmt_select 0→1 → STATUS[0] reads 1 no earlier than 2 cycles later. With LOCK_EN, write LOCK = 0xA5, then write USER → err, outputs unchanged.
